fft_mag_peak: RTL

FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

---
 rtl/fft_mag_peak.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fft_mag_peak.sv
// Magnitude-squared and peak-bin finder for one streamed FFT frame.
// A frame starts on fft_done high, captures N_BINS bins and reports the largest bin once the frame is complete.
module fft_mag_peak #(
  parameter int N_BINS      = 32,
  parameter int START_DELAY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fft_done,
  input  logic signed [15:0] data_real_in,
  input  logic signed [15:0] data_imag_in,
  output logic [31:0]        mag_out,
  output logic               mag_valid,
  output logic [7:0]         mag_bin,
  output logic [31:0]        peak_mag,
  output logic [7:0]         peak_bin,
  output logic               peak_valid,
  output logic               busy
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] LAST_BIN  = 8'(N_BINS - 1);
  localparam logic [7:0] LAST_WAIT = 8'((START_DELAY == 0) ? 0 : START_DELAY - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               v1_q, v1_d;
  logic signed [31:0] prod_re_q, prod_re_d, prod_im_q, prod_im_d;
  logic [7:0]         bin1_q, bin1_d;
  logic [31:0]        mag_q, mag_d;
  logic               mag_valid_q, mag_valid_d;
  logic [7:0]         mag_bin_q, mag_bin_d;
  logic [31:0]        run_max_q, run_max_d;
  logic [7:0]         run_bin_q, run_bin_d;
  logic [31:0]        peak_mag_q, peak_mag_d;
  logic [7:0]         peak_bin_q, peak_bin_d;
  logic               peak_valid_q, peak_valid_d;

  logic        capture, start_capture, enter_done, abort;
  logic [31:0] sum;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    capture       = 1'b0;
    start_capture = 1'b0;
    enter_done    = 1'b0;
    abort         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fft_done) begin
          cnt_d = '0;
          if (START_DELAY == 0) begin
            state_d       = S_CAPTURE;
            start_capture = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!fft_done) begin
          abort = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          cnt_d         = '0;
          state_d       = S_CAPTURE;
          start_capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CAPTURE: begin
        if (!fft_done) begin
          abort = 1'b1;
        end else begin
          capture = 1'b1;
          if (cnt_q == LAST_BIN) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!fft_done) begin
          abort = 1'b1;
        end else if (cnt_q == 8'd1) begin
          cnt_d      = '0;
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (!fft_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Both products are non-negative and at most 2^30, so their sum fits 32 unsigned bits.
  assign sum = prod_re_q + prod_im_q;

  always_comb begin
    v1_d         = capture;
    prod_re_d    = prod_re_q;
    prod_im_d    = prod_im_q;
    bin1_d       = bin1_q;
    mag_valid_d  = v1_q & ~abort;
    mag_d        = mag_q;
    mag_bin_d    = mag_bin_q;
    run_max_d    = run_max_q;
    run_bin_d    = run_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_valid_d = peak_valid_q;

    if (capture) begin
      prod_re_d = 32'(data_real_in) * 32'(data_real_in);
      prod_im_d = 32'(data_imag_in) * 32'(data_imag_in);
      bin1_d    = cnt_q;
    end
    if (v1_q) begin
      mag_d     = sum;
      mag_bin_d = bin1_q;
    end

    // Strict greater-than keeps the lowest index on ties.
    if (start_capture) begin
      run_max_d = '0;
      run_bin_d = '0;
    end else if (mag_valid_q && (mag_q > run_max_q)) begin
      run_max_d = mag_q;
      run_bin_d = mag_bin_q;
    end

    if (enter_done) begin
      peak_mag_d   = run_max_d;
      peak_bin_d   = run_bin_d;
      peak_valid_d = 1'b1;
    end else if (start_capture) begin
      peak_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      v1_q         <= 1'b0;
      prod_re_q    <= '0;
      prod_im_q    <= '0;
      bin1_q       <= '0;
      mag_q        <= '0;
      mag_valid_q  <= 1'b0;
      mag_bin_q    <= '0;
      run_max_q    <= '0;
      run_bin_q    <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      v1_q         <= v1_d;
      prod_re_q    <= prod_re_d;
      prod_im_q    <= prod_im_d;
      bin1_q       <= bin1_d;
      mag_q        <= mag_d;
      mag_valid_q  <= mag_valid_d;
      mag_bin_q    <= mag_bin_d;
      run_max_q    <= run_max_d;
      run_bin_q    <= run_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign mag_out    = mag_q;
  assign mag_valid  = mag_valid_q;
  assign mag_bin    = mag_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_bin   = peak_bin_q;
  assign peak_valid = peak_valid_q;
  assign busy       = (state_q == S_WAIT) || (state_q == S_CAPTURE) || (state_q == S_DRAIN);

endmodule
